countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter with a start/stop/pause control and a terminal-count handshake. It is the decrementing counterpart of the free-running up-counter used in the test designs.
- Consumers load a value through a valid/ready handshake, then start the countdown.
- On reaching zero the block emits a one-cycle expire pulse and holds done_valid until acknowledged.
- Used as a watchdog/delay primitive in simulation test designs.

Parameters:
WIDTH, 32, width of count and load_value
PRESC_W, 8, width of prescale divider (used only with COUNTDOWN_PRESCALE_EN)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load request
load_ready  output  1  load accepted when load_valid && load_ready
load_value  input  WIDTH  initial count
start  input  1  begin/resume countdown
stop  input  1  pause countdown
count  output  WIDTH  current count value
running  output  1  high in RUN state
expire  output  1  one-cycle pulse when count reaches 0
done_valid  output  1  terminal count reached, held until done_ready
done_ready  input  1  acknowledge of done_valid
prescale  input  PRESC_W  tick divider (present only with COUNTDOWN_PRESCALE_EN)

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. While rst_n=0:
  - state=IDLE, count=0.
  - load_ready=1, running=0, expire=0, done_valid=0.
  - Prescaler (if present) =0.
- States: IDLE, ARMED, RUN, EXPIRED. All outputs are registered except load_ready and running, which decode the state.
- IDLE:
  - load_ready=1.
  - On load handshake: count<=load_value, go to ARMED.
  - start and stop are ignored.
- ARMED:
  - load_ready=1. A load handshake overwrites count.
  - start=1 and stop=0: go to RUN. If a load happens in the same cycle, the new value is the one counted.
- RUN:
  - load_ready=0. A held load_valid waits, with no side effect.
  - stop=1: go to ARMED, count held (pause). stop wins over start in the same cycle.
  - Otherwise, on each tick:
    - count>1: count<=count-1.
    - count==1 or count==0: count<=0, expire=1 for exactly one cycle, go to EXPIRED.
  - A zero load therefore expires one cycle after start. count never wraps below 0.
- Tick without the macro: every clk cycle. Latency from start sampled high to expire high is N cycles for load N≥1, and 1 cycle for N=0.
- EXPIRED:
  - done_valid=1, count=0, load_ready=0.
  - done_ready=1: done_valid<=0, go to IDLE.
  - done_ready may already be high on the expire cycle; the handshake then completes on the first EXPIRED cycle.
  - start, stop and load are ignored.
- Reset mid-operation aborts immediately. No expire is generated and count returns to 0.
- Arithmetic is unsigned, WIDTH bits. Decrement never underflows.

Optional Feature:
- Macro: COUNTDOWN_PRESCALE_EN.
- Defined:
  - Adds the prescale port and a PRESC_W-bit prescaler counter.
  - A tick occurs when the prescaler equals prescale; the prescaler then clears.
  - The prescaler increments only in RUN. It clears on entry to RUN from ARMED and on any load.
  - prescale=0 gives a tick every cycle.
  - Latency for load N is N*(prescale+1) cycles.
- Not defined: no prescale port, tick every cycle in RUN.

Decomposition:
- Package countdown_pkg holds:
  - the state enum typedef (IDLE, ARMED, RUN, EXPIRED);
  - a default WIDTH localparam.
- One natural sub-module, countdown_prescaler: tick generator with clk, rst_n, enable, clear, prescale, tick. It is instantiated only under COUNTDOWN_PRESCALE_EN.

Test Plan:
- Reset and expire: reset, load 5, start one cycle.
  - count 5,4,3,2,1,0 on successive cycles.
  - expire high exactly on the cycle count becomes 0.
  - done_valid then held until done_ready, then back to IDLE with load_ready=1.
- Pause and resume: load 10, start, stop after 3 ticks.
  - count holds 7 for 4 cycles.
  - Restart: expire 7 cycles later.
  - start and stop together in RUN: stays paused.
- Zero load: load 0, start → expire 1 cycle later, count stays 0, no wrap to all-ones.
- Load/start in same cycle: in ARMED holding 8, load 3 and start together → expire after 3 ticks. load_valid during RUN: load_ready=0, count unaffected.
- Async reset mid-run: load 100, start, drop rst_n at count 40 between clock edges.
  - count=0, running=0, done_valid=0 immediately.
  - No expire pulse.
- With COUNTDOWN_PRESCALE_EN: prescale=2, load 4, start → count decrements every 3 cycles, expire at cycle 12.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: state encoding and default width.
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_prescaler.sv
// Tick generator for the countdown timer. The phase counter advances while
// enabled and wraps when it matches the programmed divider, producing a
// tick every (prescale+1) enabled cycles. Used only when the timer is built
// with COUNTDOWN_PRESCALE_EN.
module countdown_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] phase;

  assign tick = enable && (phase == prescale);

  // Phase counter: clear has priority, otherwise count up and wrap on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= tick ? '0 : phase + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume and a terminal-count handshake.
// A value is loaded in IDLE/ARMED, start begins counting, stop pauses back
// to ARMED, and reaching zero raises a one-cycle expire pulse plus a
// done_valid flag that is held until done_ready.
// Optional build macro COUNTDOWN_PRESCALE_EN adds a prescale port and a
// tick divider so that the count steps every (prescale+1) cycles.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef COUNTDOWN_PRESCALE_EN
  ,
  parameter int PRESC_W = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_value,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               running,
  output logic               expire,
  output logic               done_valid,
  input  logic               done_ready
`ifdef COUNTDOWN_PRESCALE_EN
  ,
  input  logic [PRESC_W-1:0] prescale
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  logic   tick;

  // load_ready and running are pure state decodes; everything else is registered.
  assign load_ready = (state == IDLE) || (state == ARMED);
  assign running    = (state == RUN);

`ifdef COUNTDOWN_PRESCALE_EN
  logic load_fire;
  logic run_entry;

  assign load_fire = load_valid && load_ready;
  assign run_entry = (state == ARMED) && start && !stop;

  // The divider restarts from zero on every load and on every (re)start,
  // so a resumed countdown always sees a full prescale period first.
  countdown_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (running),
    .clear    (load_fire || run_entry),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = running;
`endif

  // Control FSM with registered count, expire pulse and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      expire     <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            count <= load_value;
            state <= ARMED;
          end
        end
        ARMED: begin
          // A same-cycle load and start counts the newly loaded value.
          if (load_valid) begin
            count <= load_value;
          end
          if (start && !stop) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= ARMED;
          end else if (tick) begin
            // Counts of 1 and 0 both terminate, so the counter never wraps.
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              count      <= '0;
              expire     <= 1'b1;
              done_valid <= 1'b1;
              state      <= EXPIRED;
            end
          end
        end
        EXPIRED: begin
          count <= '0;
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the timer.
`timescale 1ns/1ps
module tb_countdown_timer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             done_ready = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expire;
  logic             done_valid;
`ifdef COUNTDOWN_PRESCALE_EN
  logic [7:0]       prescale = 8'd0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_timer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .running    (running),
    .expire     (expire),
    .done_valid (done_valid),
    .done_ready (done_ready)
`ifdef COUNTDOWN_PRESCALE_EN
    ,
    .prescale   (prescale)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a value is either absent, held (armed), being
  // counted, or finished and awaiting acknowledge.
  bit               m_have = 1'b0;
  bit               m_counting = 1'b0;
  bit               m_waiting = 1'b0;
  bit               m_expire = 1'b0;
  logic [WIDTH-1:0] m_count = '0;
  int               m_phase = 0;

  initial forever begin
    bit tk;
    bit prev_have;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_have = 0; m_counting = 0; m_waiting = 0; m_expire = 0;
      m_count = '0; m_phase = 0;
    end else begin
      m_expire = 0;
      if (m_waiting) begin
        if (done_ready) begin
          m_waiting = 0;
          m_have = 0;
        end
      end else if (m_counting) begin
        if (stop) begin
          m_counting = 0;
        end else begin
`ifdef COUNTDOWN_PRESCALE_EN
          tk = (m_phase == int'(prescale));
`else
          tk = 1'b1;
`endif
          if (tk) m_phase = 0;
          else m_phase++;
          if (tk) begin
            if (m_count <= 1) begin
              m_count = '0;
              m_expire = 1;
              m_counting = 0;
              m_waiting = 1;
            end else begin
              m_count = m_count - 1;
            end
          end
        end
      end else begin
        prev_have = m_have;
        if (load_valid) begin
          m_count = load_value;
          m_have = 1;
          m_phase = 0;
        end
        if (prev_have && start && !stop) begin
          m_counting = 1;
          m_phase = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    chk("cmp_count", count, m_count);
    chk("cmp_load_ready", load_ready, !m_counting && !m_waiting);
    chk("cmp_running", running, m_counting);
    chk("cmp_expire", expire, m_expire);
    chk("cmp_done_valid", done_valid, m_waiting);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_then_start(input logic [WIDTH-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    cyc();
    load_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_count", count, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_expire", expire, 0);
    chk("rst_done_valid", done_valid, 0);
    rst_n = 1'b1;
    cyc();

    // Load 5, count to expiry, hold done until acknowledged
    load_then_start(5);
    chk("t1_count_start", count, 5);
    chk("t1_running", running, 1);
    for (int k = 4; k >= 0; k--) begin
      cyc();
      chk("t1_count", count, k);
      chk("t1_expire", expire, (k == 0));
    end
    chk("t1_done_set", done_valid, 1);
    chk("t1_load_ready_exp", load_ready, 0);
    repeat (3) begin
      cyc();
      chk("t1_done_hold", done_valid, 1);
      chk("t1_expire_once", expire, 0);
    end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
    chk("t1_done_clr", done_valid, 0);
    chk("t1_idle_ready", load_ready, 1);

    // Pause and resume
    load_then_start(10);
    repeat (3) cyc();
    chk("t2_count_before_stop", count, 7);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_pause_count", count, 7);
      chk("t2_pause_running", running, 0);
      cyc();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_resumed", running, 1);
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("t2_stop_wins", running, 0);
    chk("t2_stop_wins_count", count, 7);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 6; k >= 0; k--) begin
      cyc();
      chk("t2_count", count, k);
      chk("t2_expire", expire, (k == 0));
    end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;

    // Zero load
    load_then_start(0);
    chk("t3_running", running, 1);
    chk("t3_no_early_expire", expire, 0);
    cyc();
    chk("t3_expire", expire, 1);
    chk("t3_count", count, 0);
    cyc();
    chk("t3_no_wrap", count, 0);
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;

    // Load and start together in ARMED; load held during RUN
    load_valid = 1'b1;
    load_value = 8;
    cyc();
    load_value = 3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_value = 99;
    chk("t4_new_value", count, 3);
    chk("t4_ready_low", load_ready, 0);
    cyc();
    chk("t4_count2", count, 2);
    cyc();
    chk("t4_count1", count, 1);
    cyc();
    chk("t4_expire", expire, 1);
    load_valid = 1'b0;
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
    chk("t4_back_idle", load_ready, 1);
    chk("t4_load_ignored", count, 0);

    // Asynchronous reset mid-run
    load_then_start(100);
    repeat (60) cyc();
    chk("t5_count40", count, 40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_count", count, 0);
    chk("t5_rst_running", running, 0);
    chk("t5_rst_done", done_valid, 0);
    chk("t5_rst_expire", expire, 0);
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("t5_no_expire", expire, 0);
    end

`ifdef COUNTDOWN_PRESCALE_EN
    // Prescaled countdown: step every 3 cycles, expire on cycle 12
    prescale = 8'd2;
    load_then_start(4);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("t6_count", count, 4 - c / 3);
      chk("t6_expire", expire, (c == 12));
    end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if ($urandom_range(0, 599) == 0) begin
        #2;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
      end
      load_valid = ($urandom_range(0, 9) < 3);
      load_value = WIDTH'($urandom_range(0, 12));
      start      = ($urandom_range(0, 9) < 2);
      stop       = ($urandom_range(0, 19) < 1);
      done_ready = ($urandom_range(0, 9) < 3);
`ifdef COUNTDOWN_PRESCALE_EN
      if ($urandom_range(0, 99) == 0) prescale = 8'($urandom_range(0, 3));
`endif
    end
    load_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cyc();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
